deconv_kernel_magnitude_sram_interface: RTL and testbench

Output-side SRAM interface for the deconvolution-kernel frequency-response magnitude (and phase) store. It captures a stream of DATA_WIDTH-bit results into a 2*DEPTH-word buffer with an auto-incrementing write pointer. In debug mode it replays the buffer word by word to the downstream `serializer`, which shifts each word out LSB first. Read and write ports are independent, so new data can be written while older contents are being read out.

---
 rtl/deconv_kernel_magnitude_sram_interface.sv | 83 ++++++++
 tb/tb_deconv_kernel_magnitude_sram_interface.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/deconv_kernel_magnitude_sram_interface.sv
// Output SRAM buffer for deconv kernel magnitude/phase with debug serial readout.
// Define OUTPUT_SRAM_WRITE_WRAP_EN to wrap the write pointer instead of saturating.
module deconv_kernel_magnitude_sram_interface #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 12,
  parameter int DEPTH      = 2048
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  debug,
  input  logic                  debug_read_trig,
  input  logic                  wen,
  input  logic [DATA_WIDTH-1:0] wdata_in,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int WORDS = 2 * DEPTH;
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(WORDS - 1);

  logic [DATA_WIDTH-1:0] mem [WORDS];
  logic [ADDR_WIDTH-1:0] waddr;
  logic [ADDR_WIDTH-1:0] raddr;
  logic [ADDR_WIDTH-1:0] waddr_nxt;
  logic [ADDR_WIDTH-1:0] raddr_nxt;
  logic [DATA_WIDTH-1:0] stage1;
  logic                  wr_ok;

  assign waddr_nxt = (waddr == LAST) ? '0 : waddr + 1'b1;
  assign raddr_nxt = (raddr == LAST) ? '0 : raddr + 1'b1;

`ifdef OUTPUT_SRAM_WRITE_WRAP_EN
  assign wr_ok = wen;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      waddr <= '0;
    end else if (wr_ok) begin
      waddr <= waddr_nxt;
    end
  end
`else
  // full marks the pointer having reached 2*DEPTH; writes stop until reset
  logic full;

  assign wr_ok = wen && !full;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      waddr <= '0;
      full  <= 1'b0;
    end else if (wr_ok) begin
      waddr <= waddr_nxt;
      if (waddr == LAST) full <= 1'b1;
    end
  end
`endif

  // Contents survive reset; reset only blocks the write
  always_ff @(posedge clk) begin
    if (rst_n && wr_ok) mem[waddr] <= wdata_in;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      raddr <= '0;
    end else if (!debug) begin
      raddr <= '0;
    end else if (debug_read_trig) begin
      raddr <= raddr_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stage1 <= '0;
      rdata  <= '0;
    end else begin
      stage1 <= mem[raddr];
      rdata  <= stage1;
    end
  end

endmodule

// File: tb/tb_deconv_kernel_magnitude_sram_interface.sv
// Scoreboard bench for deconv_kernel_magnitude_sram_interface.
// Honors OUTPUT_SRAM_WRITE_WRAP_EN for the overflow expectation.
module tb_deconv_kernel_magnitude_sram_interface;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        debug = 1'b0;
  logic        debug_read_trig = 1'b0;
  logic        wen = 1'b0;
  logic [15:0] wdata_in = '0;
  logic [15:0] rdata;
  logic        probe = 1'b0;

  logic [15:0] expq [$];
  string       tagq [$];
  int          compared = 0;
  int          mismatched = 0;

  deconv_kernel_magnitude_sram_interface #(
    .DATA_WIDTH(16),
    .ADDR_WIDTH(12),
    .DEPTH(2048)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .debug(debug),
    .debug_read_trig(debug_read_trig),
    .wen(wen),
    .wdata_in(wdata_in),
    .rdata(rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] old_w(input int i);
    return 16'((i * 40503) ^ 23130);
  endfunction

  function automatic logic [15:0] new_w(input int i);
    return 16'(~(i * 15471 + 99));
  endfunction

  function automatic logic [15:0] ovf_w(input int i);
    return 16'((i * 7) ^ 16'hC3A5);
  endfunction

  // The serializer latches rdata on the edge ending a fetch cycle
  always @(negedge clk) begin
    if (debug_read_trig || probe) begin
      logic [15:0] e;
      string t;
      compared++;
      if (expq.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_output: rdata=%h with no expected word", rdata);
      end else begin
        e = expq.pop_front();
        t = tagq.pop_front();
        if (rdata !== e) begin
          mismatched++;
          $display("FAIL %s: got %h expected %h", t, rdata, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_word(input logic [15:0] v, input string tag);
    expq.push_back(v);
    tagq.push_back(tag);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    probe = 1'b1;
    expect_word(16'h0000, tag);
    tick();
    probe = 1'b0;
  endtask

  task automatic readout(input bit use_new, input bit cw, input string tag);
    debug = 1'b1;
    repeat (3) tick();
    for (int i = 0; i < 4096; i++) begin
      debug_read_trig = 1'b1;
      expect_word(use_new ? new_w(i) : old_w(i), tag);
      if (cw && i >= 2) begin
        wen = 1'b1;
        wdata_in = new_w(i - 2);
      end
      tick();
      debug_read_trig = 1'b0;
      wen = 1'b0;
      tick();
      tick();
    end
    debug = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    do_reset("reset_state");

    for (int i = 0; i < 4096; i++) begin
      wen = 1'b1;
      wdata_in = old_w(i);
      tick();
    end
    wen = 1'b0;
    tick();
    readout(1'b0, 1'b0, "fill_read");

    do_reset("rdata_zero_in_reset");
    readout(1'b0, 1'b1, "retain_concurrent");
    for (int i = 4094; i < 4096; i++) begin
      wen = 1'b1;
      wdata_in = new_w(i);
      tick();
    end
    wen = 1'b0;

    repeat (3) tick();
    readout(1'b1, 1'b0, "rptr_clear_new");

    do_reset("reset_before_collision");
    debug = 1'b1;
    tick();
    tick();
    wen = 1'b1;
    wdata_in = 16'h1234;
    tick();
    wen = 1'b0;
    tick();
    probe = 1'b1;
    expect_word(new_w(0), "collision_old");
    tick();
    expect_word(16'h1234, "collision_new");
    tick();
    probe = 1'b0;
    debug = 1'b0;

    do_reset("reset_before_overflow");
    for (int i = 0; i < 4096; i++) begin
      wen = 1'b1;
      wdata_in = ovf_w(i);
      tick();
    end
    wdata_in = 16'hBEEF;
    tick();
    wen = 1'b0;
    repeat (3) tick();
    probe = 1'b1;
`ifdef OUTPUT_SRAM_WRITE_WRAP_EN
    expect_word(16'hBEEF, "overflow_word0");
`else
    expect_word(ovf_w(0), "overflow_word0");
`endif
    tick();
    probe = 1'b0;

    debug = 1'b1;
    repeat (3) tick();
    debug_read_trig = 1'b1;
`ifdef OUTPUT_SRAM_WRITE_WRAP_EN
    expect_word(16'hBEEF, "overflow_fetch0");
`else
    expect_word(ovf_w(0), "overflow_fetch0");
`endif
    tick();
    debug_read_trig = 1'b0;
    tick();
    tick();
    debug_read_trig = 1'b1;
    expect_word(ovf_w(1), "overflow_fetch1");
    tick();
    debug_read_trig = 1'b0;
    debug = 1'b0;

    repeat (3) tick();
    compared++;
    if (expq.size() != 0) begin
      mismatched++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", expq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
